// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl: upstream/downstream handshakes
// plus the controller side of a synchronous, registered-read RAM.
interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             ram_wr_en;
  logic [AW-1:0]    ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;

  modport slave (
    input  s_valid, s_data, m_ready, ram_rd_data,
    output s_ready, m_valid, m_data, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport master (
    output s_valid, s_data, m_ready, ram_rd_data,
    input  s_ready, m_valid, m_data, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external RAM with one-cycle read latency; a 2-entry
// output buffer absorbs that latency so push and pop both sustain one per cycle.
module ram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  ram_fifo_ctrl_if.slave             bus,
  output logic [$clog2(DEPTH)+1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ram_cnt_q, ram_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_ready_s, push_s, pop_s, issue_s;
  logic [2:0]       occ_s;

  // Handshake decode, read scheduling and next-state for pointers and buffer
  always_comb begin
    s_ready_s  = (ram_cnt_q < (AW+1)'(DEPTH));
    push_s     = bus.s_valid && s_ready_s && !rst;
    pop_s      = (buf_cnt_q != 2'd0) && bus.m_ready;
    // buffer slots that will be committed after this edge, not counting a new issue
    occ_s      = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s    = (ram_cnt_q != (AW+1)'(0)) && (occ_s < 3'd2);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    ram_cnt_d  = ram_cnt_q + (AW+1)'(push_s) - (AW+1)'(issue_s);
    inflight_d = issue_s;
    buf_cnt_d  = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({inflight_q, pop_s})
      2'b01: begin
        buf0_d = buf1_q;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = bus.ram_rd_data;
        end else begin
          buf1_d = bus.ram_rd_data;
        end
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = bus.ram_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.ram_rd_data;
        end
      end
      default: begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
      end
    endcase

    count_d = CW'(ram_cnt_d) + CW'(inflight_d) + CW'(buf_cnt_d);
  end

  // State registers; a read in flight at reset is simply dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
    end
  end

  assign bus.s_ready     = s_ready_s;
  assign bus.m_valid     = (buf_cnt_q != 2'd0);
  assign bus.m_data      = buf0_q;
  assign bus.ram_wr_en   = push_s;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_wr_data = bus.s_data;
  assign bus.ram_rd_addr = rd_ptr_q;
  assign count           = count_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: queue-based reference model, registered-read RAM model,
// directed latency/fill/stream/reset scenarios and a long random backpressure run.
module tb_ram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [AW+1:0] count;

  ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .count (count)
  );

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read data
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int n_total = 0;
  int n_bad   = 0;

  // reference model: contents as plain queues
  int ram_q[$];
  int buf_q[$];
  bit infl;
  int infl_w;
  int mcount;
  int wr_total;
  int rd_total;

  // observations of the most recent step
  int obs_mv, obs_md, obs_count, obs_sready;
  bit prev_stall;
  int prev_md;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    ram_q.delete();
    buf_q.delete();
    infl     = 1'b0;
    infl_w   = 0;
    mcount   = 0;
    wr_total = 0;
    rd_total = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    bus.m_ready = 1'b0;
    model_clear();
    #1;
    chk("rst_wr_en",   int'(bus.ram_wr_en), 0);
    chk("rst_m_valid", int'(bus.m_valid),   0);
    chk("rst_count",   int'(count),         0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model at the edge
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    bit exp_sr, exp_mv, push, pop, issue;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    #1;
    exp_sr = (ram_q.size() < DEPTH);
    exp_mv = (buf_q.size() != 0);
    push   = sv && exp_sr;
    chk("s_ready", int'(bus.s_ready), int'(exp_sr));
    chk("m_valid", int'(bus.m_valid), int'(exp_mv));
    if (exp_mv) chk("m_data", int'(bus.m_data), buf_q[0]);
    if (prev_stall) chk("m_data_stable", int'(bus.m_data), prev_md);
    chk("count", int'(count), mcount);
    chk("ram_wr_en", int'(bus.ram_wr_en), int'(push));
    if (push) begin
      chk("ram_wr_addr", int'(bus.ram_wr_addr), wr_total % DEPTH);
      chk("ram_wr_data", int'(bus.ram_wr_data), int'(sd));
    end
    chk("ram_rd_addr", int'(bus.ram_rd_addr), rd_total % DEPTH);
    obs_mv     = int'(bus.m_valid);
    obs_md     = int'(bus.m_data);
    obs_count  = int'(count);
    obs_sready = int'(bus.s_ready);
    prev_stall = bus.m_valid && !mr;
    prev_md    = int'(bus.m_data);

    @(posedge clk);
    pop   = exp_mv && mr;
    issue = (ram_q.size() != 0) && ((buf_q.size() + int'(infl) - int'(pop)) < 2);
    if (pop) void'(buf_q.pop_front());
    if (infl) buf_q.push_back(infl_w);
    infl = issue;
    if (issue) begin
      infl_w = ram_q.pop_front();
      rd_total++;
    end
    if (push) begin
      ram_q.push_back(int'(sd));
      wr_total++;
    end
    mcount = ram_q.size() + int'(infl) + buf_q.size();
    @(negedge clk);
  endtask

  initial begin
    int exp_mv_a [5];
    int exp_cnt_a[5];
    int nacc, nout, n130;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b0;
    model_clear();
    do_reset();

    // single word latency
    exp_mv_a  = '{0, 0, 0, 1, 0};
    exp_cnt_a = '{0, 1, 1, 1, 0};
    for (int c = 0; c < 5; c++) begin
      step(c == 0, 8'hA5, 1'b1);
      chk($sformatf("lat_mv_c%0d", c), obs_mv, exp_mv_a[c]);
      chk($sformatf("lat_cnt_c%0d", c), obs_count, exp_cnt_a[c]);
      if (c == 3) chk("lat_data", obs_md, 32'hA5);
    end

    // fill with downstream stalled
    nacc = 0;
    for (int i = 0; i < 135; i++) begin
      step(1'b1, 8'(nacc), 1'b0);
      if (obs_sready != 0) nacc++;
    end
    step(1'b0, 8'h00, 1'b0);
    chk("fill_accepted", nacc, 130);
    chk("fill_s_ready",  obs_sready, 0);
    chk("fill_count",    obs_count, 130);

    // drain: strictly ordered, back-to-back
    nout = 0;
    n130 = 0;
    for (int i = 0; i < 135; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (obs_mv != 0) begin
        chk("drain_order", obs_md, nout & 255);
        nout++;
        if (i < 130) n130++;
      end
    end
    chk("drain_total",    nout, 130);
    chk("drain_streamed", n130, 130);

    // streaming across pointer wrap
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'(i), 1'b1);
      if (i >= 3) begin
        chk("stream_count", obs_count, 3);
        chk("stream_mv",    obs_mv, 1);
        chk("stream_data",  obs_md, (i - 3) & 255);
      end
    end

    // random traffic with backpressure
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // reset mid-operation with a read in flight
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'd50, 1'b1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("pre_rst_count", int'(count), 50);
    chk("pre_rst_model_inflight", int'(infl), 1);
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_mv",     obs_mv, 0);
    chk("post_rst_count",  obs_count, 0);
    chk("post_rst_sready", obs_sready, 1);
    step(1'b1, 8'h3C, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("post_rst_mv_c%0d", c), obs_mv, (c == 3) ? 1 : 0);
      if (c == 3) chk("post_rst_data", obs_md, 32'h3C);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, RAM word count; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port s_valid  input  1  upstream word available.
REQ-006 SHALL have port s_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port s_data  input  WIDTH  upstream word.
REQ-008 SHALL have port m_valid  output  1  head word available downstream.
REQ-009 SHALL have port m_ready  input  1  downstream takes the head word.
REQ-010 SHALL have port m_data  output  WIDTH  head word.
REQ-011 SHALL have port ram_wr_en  output  1  RAM write strobe.
REQ-012 SHALL have port ram_wr_addr  output  $clog2(DEPTH)  RAM write address.
REQ-013 SHALL have port ram_wr_data  output  WIDTH  RAM write data.
REQ-014 SHALL have port ram_rd_addr  output  $clog2(DEPTH)  RAM read address.
REQ-015 SHALL have port ram_rd_data  input  WIDTH  RAM registered read data, valid the cycle after ram_rd_addr is presented.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+2  total words held (RAM + in-flight + output buffer).

Function
REQ-017 Push SHALL occur when s_valid && s_ready; ram_wr_en = push, ram_wr_addr = wr_ptr, ram_wr_data = s_data, all combinational.
REQ-018 ram_cnt (words in RAM not yet read) SHALL range 0..DEPTH; s_ready = (ram_cnt < DEPTH), independent of m_ready.
REQ-019 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits, increment by 1 on push / read issue respectively, wrapping DEPTH-1 -> 0.
REQ-020 Output buffer SHALL be a 2-entry FIFO (buf_cnt 0..2); m_valid = (buf_cnt != 0), m_data = buffer head; pop = m_valid && m_ready.
REQ-021 Read issue SHALL occur when ram_cnt != 0 && (buf_cnt + inflight - pop) < 2; ram_rd_addr = rd_ptr combinationally every cycle.
REQ-022 inflight SHALL be set the cycle after a read issue and cleared otherwise; when inflight = 1, ram_rd_data SHALL be written into the buffer tail at that edge.
REQ-023 ram_cnt SHALL update as ram_cnt + push - issue; a word pushed in cycle N SHALL not be eligible for read issue before cycle N+1 (no same-address read/write in one cycle).
REQ-024 Latency: word pushed into empty block in cycle N SHALL appear with m_valid = 1 in cycle N+3.
REQ-025 Throughput: with s_valid and m_ready held high, steady state SHALL sustain one push and one pop per cycle.
REQ-026 Order SHALL be strict FIFO across RAM wrap-around.
REQ-027 count SHALL equal ram_cnt + inflight + buf_cnt, registered; maximum DEPTH+2.
REQ-028 Simultaneous push and pop SHALL be legal at all occupancies, including ram_cnt = DEPTH (push blocked, pop proceeds, s_ready rises next cycle).
REQ-029 m_data SHALL stay stable while m_valid && !m_ready.

Reset
REQ-030 On rst high, asynchronously: wr_ptr, rd_ptr, ram_cnt, inflight, buf_cnt, count = 0; m_valid = 0; s_ready = 1 after release.
REQ-031 An in-flight read at reset SHALL be discarded; RAM contents are not cleared and not relied upon.
REQ-032 ram_wr_en SHALL be 0 while rst is high regardless of s_valid.

Verification
REQ-033 Single word: push 0xA5 in cycle 0, m_ready = 1 -> m_valid = 1, m_data = 0xA5 in cycle 3 only; count 1 in cycles 1-3, 0 in cycle 4.
REQ-034 Fill: m_ready = 0, push 0..129 (DEPTH=128) -> s_ready falls after 130 accepted words, count = 130; then drain -> 0..129 in order, no gaps once streaming.
REQ-035 Streaming: s_valid, m_ready = 1 for 300 cycles with incrementing data -> one output per cycle after cycle 3, ptr wrap invisible, count constant 3.
REQ-036 Backpressure: random m_ready (50%) and s_valid (50%) for 10000 cycles -> scoreboard order match, m_data stable while stalled, count matches model.
REQ-037 Reset mid-operation: assert rst with count = 50 and a read in flight -> next cycle after release m_valid = 0, count = 0, s_ready = 1; subsequent push 0x3C emerges unchanged after 3 cycles.
